// File: rtl/contador_ascendente.sv
// rtl/contador_ascendente.sv - N-bit up-counter with load, inclusive limit, wrap/saturate, tc pulse and sticky overflow
module contador_ascendente #(
   parameter int N = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] inicial,
   input  logic         cargar,
   input  logic         incrementar,
   input  logic [N-1:0] limite,
   input  logic         saturar,
   input  logic         clr_ovf,
   output logic [N-1:0] out,
   output logic         tc,
   output logic         overflow
);

   logic [N-1:0] out_q, out_d;
   logic         tc_q, tc_d;
   logic         ovf_q, ovf_d;
   logic [N-1:0] load_val;
   logic [N-1:0] out_inc;

   // Loads are clamped so the count never starts above the limit.
   assign load_val = (inicial < limite) ? inicial : limite;
   assign out_inc  = out_q + {{(N-1){1'b0}}, 1'b1};

   always_comb begin
      out_d = out_q;
      tc_d  = 1'b0;
      ovf_d = ovf_q & ~clr_ovf;
      if (cargar) begin
         out_d = load_val;
      end else if (incrementar) begin
         if (out_q < limite) begin
            out_d = out_inc;
            tc_d  = (out_inc == limite);
         end else if (!saturar) begin
            // A wrap overrides a simultaneous clr_ovf.
            out_d = '0;
            ovf_d = 1'b1;
         end else begin
            out_d = limite;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= load_val;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         out_q <= out_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
      end
   end

   assign out      = out_q;
   assign tc       = tc_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_contador_ascendente.sv
// tb/tb_contador_ascendente.sv - directed scoreboard bench for contador_ascendente
module tb_contador_ascendente;

   localparam int N = 6;

   logic         clk = 1'b0;
   logic         rst, cargar, incrementar, saturar, clr_ovf;
   logic [N-1:0] inicial, limite;
   logic [N-1:0] out;
   logic         tc, overflow;

   typedef struct packed {
      logic [N-1:0] out;
      logic         tc;
      logic         ovf;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [N-1:0] m_out = '0;
   logic         m_tc  = 1'b0;
   logic         m_ovf = 1'b0;

   contador_ascendente #(.N(N)) dut (
      .clk(clk), .rst(rst), .inicial(inicial), .cargar(cargar),
      .incrementar(incrementar), .limite(limite), .saturar(saturar),
      .clr_ovf(clr_ovf), .out(out), .tc(tc), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Reference behaviour: evaluate the inputs now applied, push expectation, clock, compare.
   task automatic step(input string tag);
      exp_t e;
      logic [N-1:0] ld;
      ld = (inicial < limite) ? inicial : limite;
      if (rst) begin
         m_out = ld; m_tc = 1'b0; m_ovf = 1'b0;
      end else begin
         if (clr_ovf) m_ovf = 1'b0;
         m_tc = 1'b0;
         if (cargar) begin
            m_out = ld;
         end else if (incrementar) begin
            if (int'(m_out) < int'(limite)) begin
               m_out = m_out + 1'b1;
               m_tc  = (m_out == limite);
            end else if (!saturar) begin
               m_out = '0; m_ovf = 1'b1;
            end else begin
               m_out = limite;
            end
         end
      end
      e.out = m_out; e.tc = m_tc; e.ovf = m_ovf;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk({tag, ".out"}, int'(out), int'(e.out));
      chk({tag, ".tc"}, int'(tc), int'(e.tc));
      chk({tag, ".ovf"}, int'(overflow), int'(e.ovf));
   endtask

   initial begin
      rst = 1'b1; cargar = 1'b0; incrementar = 1'b0; saturar = 1'b0; clr_ovf = 1'b0;
      inicial = 6'd37; limite = 6'd63;
      step("reset");
      chk("reset.out_const", int'(out), 37);
      rst = 1'b0; inicial = 6'd50; cargar = 1'b1;
      step("load50");
      chk("load50.out_const", int'(out), 50);

      // count to 40 and wrap
      inicial = 6'd37; limite = 6'd40;
      step("load37");
      cargar = 1'b0; incrementar = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step("wrap");
         if (i == 2) chk("wrap.tc_at_40", int'(tc), 1);
         if (i == 3) begin
            chk("wrap.out0", int'(out), 0);
            chk("wrap.ovf_set", int'(overflow), 1);
         end
      end
      chk("wrap.out_2", int'(out), 2);

      // saturate; clr_ovf during the load clears the old flag
      incrementar = 1'b0; cargar = 1'b1; clr_ovf = 1'b1;
      step("sat.load");
      cargar = 1'b0; clr_ovf = 1'b0; saturar = 1'b1; incrementar = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step("sat");
         if (i == 2) chk("sat.tc_first", int'(tc), 1);
         if (i > 2) chk("sat.tc_hold", int'(tc), 0);
      end
      chk("sat.out40", int'(out), 40);
      chk("sat.ovf0", int'(overflow), 0);

      // gated increments 1,0,1,1,0
      saturar = 1'b0; limite = 6'd63; incrementar = 1'b0; cargar = 1'b1;
      step("gate.load");
      cargar = 1'b0;
      incrementar = 1'b1; step("gate1");
      incrementar = 1'b0; step("gate0");
      incrementar = 1'b1; step("gate1b");
      step("gate1c");
      incrementar = 1'b0; step("gate0b");
      chk("gate.out40", int'(out), 40);

      // limit lowered below count, then clamped load
      inicial = 6'd30; cargar = 1'b1;
      step("low.load30");
      cargar = 1'b0; limite = 6'd20; incrementar = 1'b1;
      step("low.wrap");
      chk("low.out0", int'(out), 0);
      chk("low.ovf1", int'(overflow), 1);
      incrementar = 1'b0; inicial = 6'd50; cargar = 1'b1;
      step("low.clamp");
      chk("low.out20", int'(out), 20);

      // clr_ovf colliding with a wrap, then alone
      cargar = 1'b0; incrementar = 1'b1; clr_ovf = 1'b1;
      step("coll.wrap_clr");
      chk("coll.ovf_wins", int'(overflow), 1);
      incrementar = 1'b0;
      step("coll.clr");
      chk("coll.ovf_cleared", int'(overflow), 0);

      // limite=0: stuck at zero, every increment flags overflow
      clr_ovf = 1'b0; limite = 6'd0; incrementar = 1'b1;
      step("zero.a");
      step("zero.b");
      chk("zero.ovf", int'(overflow), 1);

      // full range 62 -> 63 -> 0
      limite = 6'd63; inicial = 6'd62; cargar = 1'b1; incrementar = 1'b0;
      step("full.load");
      cargar = 1'b0; incrementar = 1'b1;
      step("full.63");
      chk("full.tc", int'(tc), 1);
      step("full.0");

      // rst beats cargar and incrementar
      rst = 1'b1; cargar = 1'b1; inicial = 6'd50;
      step("prio");
      chk("prio.out", int'(out), 50);
      chk("prio.ovf", int'(overflow), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
